// File: rtl/flappy_game_core.sv
// Flappy Bird game engine: bird physics, N-pipe obstacle field with LFSR gaps,
// collision detection, scoring with high-score retention and a four-state FSM.
// All motion advances only on the tick enable; outputs are registered.

// One obstacle column: position, gap, wrap-around and per-pipe hit/pass flags.
module flappy_pipe #(
    parameter int IDX          = 0,
    parameter int NUM_PIPES    = 3,
    parameter int SCREEN_W     = 640,
    parameter int BIRD_X       = 160,
    parameter int BIRD_SIZE    = 16,
    parameter int PIPE_W       = 40,
    parameter int PIPE_SPACING = 220,
    parameter int PIPE_SPEED   = 2,
    parameter int GAP_H        = 120,
    parameter int GAP_MIN      = 40
) (
    input  logic        clk_i,
    input  logic        clr_ni,
    input  logic        restart_i,
    input  logic        step_i,
    input  logic [7:0]  lfsr_i,
    input  logic [9:0]  bird_y_i,
    output logic [10:0] x_o,
    output logic [8:0]  gap_o,
    output logic        pass_o,
    output logic        col_o
);
    localparam logic [10:0] X_RST   = 11'(SCREEN_W + IDX * PIPE_SPACING);
    localparam logic [10:0] X_WRAP  = 11'(NUM_PIPES * PIPE_SPACING - PIPE_SPEED);
    localparam logic [10:0] SPD     = 11'(PIPE_SPEED);
    localparam logic [8:0]  GMIN9   = 9'(GAP_MIN);
    localparam logic [8:0]  GAP_RST = 9'(GAP_MIN + 8'hA5);
    localparam logic [11:0] PW12    = 12'(PIPE_W);
    localparam logic [11:0] BX12    = 12'(BIRD_X);
    localparam logic [11:0] BXE12   = 12'(BIRD_X + BIRD_SIZE);
    localparam logic [11:0] BS12    = 12'(BIRD_SIZE);
    localparam logic [11:0] GH12    = 12'(GAP_H);

    logic [10:0] x_q, x_d, x_mv;
    logic [8:0]  gap_q, gap_d;
    logic        wrap;

    assign x_mv = x_q - SPD;
    assign wrap = (x_q <= SPD);

    // Trailing edge crosses the bird's left edge on this step (never on a wrap).
    assign pass_o = !wrap && (({1'b0, x_q} + PW12) >= BX12) && (({1'b0, x_mv} + PW12) < BX12);

    // Horizontal overlap with the bird and bird outside the gap.
    assign col_o = ({1'b0, x_q} < BXE12) && (({1'b0, x_q} + PW12) > BX12) &&
                   (({2'b00, bird_y_i} < {3'b000, gap_q}) ||
                    (({2'b00, bird_y_i} + BS12) > ({3'b000, gap_q} + GH12)));

    // Next position: reload on restart, scroll left on a step, wrap to the back.
    always_comb begin
        x_d   = x_q;
        gap_d = gap_q;
        if (restart_i) begin
            x_d   = X_RST;
            gap_d = GAP_RST;
        end else if (step_i) begin
            if (wrap) begin
                x_d   = x_q + X_WRAP;
                gap_d = GMIN9 + {1'b0, lfsr_i};
            end else begin
                x_d = x_mv;
            end
        end
    end

    // Pipe registers.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            x_q   <= X_RST;
            gap_q <= GAP_RST;
        end else begin
            x_q   <= x_d;
            gap_q <= gap_d;
        end
    end

    assign x_o   = x_q;
    assign gap_o = gap_q;
endmodule

module flappy_game_core #(
    parameter int NUM_PIPES    = 3,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BIRD_X       = 160,
    parameter int BIRD_SIZE    = 16,
    parameter int PIPE_W       = 40,
    parameter int PIPE_SPACING = 220,
    parameter int PIPE_SPEED   = 2,
    parameter int GAP_H        = 120,
    parameter int GAP_MIN      = 40,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = 8,
    parameter int VMAX         = 10,
    parameter int SCORE_W      = 10
) (
    input  logic                     clk_i,
    input  logic                     clr_ni,
    input  logic                     tick_i,
    input  logic                     flap_i,
    input  logic                     pause_i,
    output logic [1:0]               game_state_o,
    output logic [9:0]               bird_y_o,
    output logic [11*NUM_PIPES-1:0]  pipe_x_o,
    output logic [9*NUM_PIPES-1:0]   pipe_gap_y_o,
    output logic [SCORE_W-1:0]       current_score_o,
    output logic [SCORE_W-1:0]       highest_score_o,
    output logic                     hit_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PLAY   = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DEAD   = 2'd3;

    localparam logic [9:0]         Y_RST    = 10'(SCREEN_H / 2 - BIRD_SIZE / 2);
    localparam logic [11:0]        BS12     = 12'(BIRD_SIZE);
    localparam logic [11:0]        SH12     = 12'(SCREEN_H);
    localparam logic signed [6:0]  GRAV7    = 7'(GRAVITY);
    localparam logic signed [6:0]  VMAX7    = 7'(VMAX);
    localparam logic signed [5:0]  VMAX6    = 6'(VMAX);
    localparam logic signed [5:0]  FLAP_NEG = 6'(-FLAP_VEL);

    logic [1:0]          state_q, state_d;
    logic signed [5:0]   vy_q, vy_d, vy_new;
    logic signed [6:0]   vy_sum;
    logic signed [11:0]  y_sum;
    logic [9:0]          bird_y_q, bird_y_d;
    logic                flap_pend_q, flap_pend_d;
    logic [SCORE_W-1:0]  score_q, score_d, high_q;
    logic [SCORE_W:0]    pass_cnt, score_sum;
    logic                hit_q, hit_d;
    logic [7:0]          lfsr_q;
    logic [NUM_PIPES-1:0] pipe_pass, pipe_col;
    logic                collide, step, restart;

    // Pipe field: one instance per column.
    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        flappy_pipe #(
            .IDX(i), .NUM_PIPES(NUM_PIPES), .SCREEN_W(SCREEN_W), .BIRD_X(BIRD_X),
            .BIRD_SIZE(BIRD_SIZE), .PIPE_W(PIPE_W), .PIPE_SPACING(PIPE_SPACING),
            .PIPE_SPEED(PIPE_SPEED), .GAP_H(GAP_H), .GAP_MIN(GAP_MIN)
        ) u_pipe (
            .clk_i    (clk_i),
            .clr_ni   (clr_ni),
            .restart_i(restart),
            .step_i   (step),
            .lfsr_i   (lfsr_q),
            .bird_y_i (bird_y_q),
            .x_o      (pipe_x_o[11*i +: 11]),
            .gap_o    (pipe_gap_y_o[9*i +: 9]),
            .pass_o   (pipe_pass[i]),
            .col_o    (pipe_col[i])
        );
    end

    assign collide = ((({2'b00, bird_y_q}) + BS12) >= SH12) || (|pipe_col);
    assign step    = (state_q == S_PLAY) && tick_i && !collide && !pause_i;
    assign restart = (state_q == S_DEAD) && flap_i;

    // Bird physics: a flap (pending or same-cycle) overrides gravity.
    assign vy_sum = $signed({vy_q[5], vy_q}) + GRAV7;
    assign vy_new = (flap_pend_q || flap_i) ? FLAP_NEG :
                    (vy_sum > VMAX7) ? VMAX6 : $signed(vy_sum[5:0]);
    assign y_sum  = $signed({2'b00, bird_y_q}) + $signed({{6{vy_new[5]}}, vy_new});

    // Number of pipes whose trailing edge passes the bird this tick.
    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++)
            pass_cnt = pass_cnt + {{SCORE_W{1'b0}}, pipe_pass[i]};
    end
    assign score_sum = {1'b0, score_q} + pass_cnt;

    // Game FSM and bird/score next state; collision takes priority over pause.
    always_comb begin
        state_d     = state_q;
        vy_d        = vy_q;
        bird_y_d    = bird_y_q;
        flap_pend_d = flap_pend_q;
        score_d     = score_q;
        hit_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flap_i) begin
                    state_d = S_PLAY;
                    vy_d    = FLAP_NEG;
                end
            end
            S_PLAY: begin
                if (collide) begin
                    state_d = S_DEAD;
                    hit_d   = 1'b1;
                end else if (pause_i) begin
                    state_d = S_PAUSED;
                end else if (tick_i) begin
                    flap_pend_d = 1'b0;
                    if (y_sum < 12'sd0) begin
                        bird_y_d = '0;
                        vy_d     = '0;
                    end else begin
                        bird_y_d = y_sum[9:0];
                        vy_d     = vy_new;
                    end
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                end else if (flap_i) begin
                    flap_pend_d = 1'b1;
                end
            end
            S_PAUSED: begin
                if (pause_i) state_d = S_PLAY;
            end
            default: begin
                if (flap_i) begin
                    state_d     = S_IDLE;
                    vy_d        = '0;
                    bird_y_d    = Y_RST;
                    score_d     = '0;
                    flap_pend_d = 1'b0;
                end
            end
        endcase
    end

    // Core game registers.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q     <= S_IDLE;
            vy_q        <= '0;
            bird_y_q    <= Y_RST;
            flap_pend_q <= 1'b0;
            score_q     <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vy_q        <= vy_d;
            bird_y_q    <= bird_y_d;
            flap_pend_q <= flap_pend_d;
            score_q     <= score_d;
            hit_q       <= hit_d;
        end
    end

    // High score follows the current score one cycle after it is exceeded.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni)              high_q <= '0;
        else if (score_q > high_q) high_q <= score_q;
    end

    // Free-running gap generator, x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) lfsr_q <= 8'hA5;
        else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign game_state_o    = state_q;
    assign bird_y_o        = bird_y_q;
    assign current_score_o = score_q;
    assign highest_score_o = high_q;
    assign hit_o           = hit_q;
endmodule

// File: tb/tb_flappy_game_core.sv
// Directed bench for flappy_game_core: default geometry (A), a zero-gravity
// scoring setup (B) and a single-pipe zero-gravity setup for wrap-around (C).
module tb_flappy_game_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_n;
    logic [2:0] tick_v, flap_v, pause_v;
    int checks = 0;
    int errors = 0;

    logic [1:0]  st_a, st_b, st_c;
    logic [9:0]  by_a, by_b, by_c;
    logic [32:0] px_a, px_b;
    logic [10:0] px_c;
    logic [26:0] gy_a, gy_b;
    logic [8:0]  gy_c;
    logic [9:0]  cs_a, hs_a, cs_b, hs_b, cs_c, hs_c;
    logic        hit_a, hit_b, hit_c;

    flappy_game_core dut_a (
        .clk_i(clk), .clr_ni(clr_n), .tick_i(tick_v[0]), .flap_i(flap_v[0]), .pause_i(pause_v[0]),
        .game_state_o(st_a), .bird_y_o(by_a), .pipe_x_o(px_a), .pipe_gap_y_o(gy_a),
        .current_score_o(cs_a), .highest_score_o(hs_a), .hit_o(hit_a));

    flappy_game_core #(.GRAVITY(0), .FLAP_VEL(0), .SCREEN_H(600), .GAP_MIN(0), .GAP_H(512)) dut_b (
        .clk_i(clk), .clr_ni(clr_n), .tick_i(tick_v[1]), .flap_i(flap_v[1]), .pause_i(pause_v[1]),
        .game_state_o(st_b), .bird_y_o(by_b), .pipe_x_o(px_b), .pipe_gap_y_o(gy_b),
        .current_score_o(cs_b), .highest_score_o(hs_b), .hit_o(hit_b));

    flappy_game_core #(.NUM_PIPES(1), .GRAVITY(0), .FLAP_VEL(0), .SCREEN_H(600), .GAP_MIN(40), .GAP_H(512)) dut_c (
        .clk_i(clk), .clr_ni(clr_n), .tick_i(tick_v[2]), .flap_i(flap_v[2]), .pause_i(pause_v[2]),
        .game_state_o(st_c), .bird_y_o(by_c), .pipe_x_o(px_c), .pipe_gap_y_o(gy_c),
        .current_score_o(cs_c), .highest_score_o(hs_c), .hit_o(hit_c));

    // Reference LFSR; lfsr_prev holds the value the DUT used at the last edge.
    logic [7:0] lfsr_m, lfsr_prev;
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lfsr_m    <= 8'hA5;
            lfsr_prev <= 8'hA5;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulse_tick(input int k);
        tick_v[k] = 1'b1; cyc(); tick_v[k] = 1'b0; cyc();
    endtask

    task automatic pulse_flap(input int k);
        flap_v[k] = 1'b1; cyc(); flap_v[k] = 1'b0;
    endtask

    task automatic pulse_pause(input int k);
        pause_v[k] = 1'b1; cyc(); pause_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        cyc(); cyc();
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st_a); end
        checks++; if (by_a !== 10'd232) begin errors++; $display("FAIL reset_bird_y got %0d exp 232", by_a); end
        checks++; if (px_a !== {11'd1080, 11'd860, 11'd640}) begin errors++; $display("FAIL reset_pipe_x got %h exp %h", px_a, {11'd1080, 11'd860, 11'd640}); end
        checks++; if (gy_a !== {9'd205, 9'd205, 9'd205}) begin errors++; $display("FAIL reset_gap got %h", gy_a); end
        checks++; if (cs_a !== 10'd0 || hs_a !== 10'd0 || hit_a !== 1'b0) begin errors++; $display("FAIL reset_score cs %0d hs %0d hit %0d exp 0", cs_a, hs_a, hit_a); end
        checks++; if (by_b !== 10'd292 || gy_b !== {9'd165, 9'd165, 9'd165}) begin errors++; $display("FAIL reset_b bird_y %0d gap %h exp 292", by_b, gy_b); end
        clr_n = 1'b1;
        cyc();
    endtask

    task automatic test_first_tick();
        pulse_flap(0);
        checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL idle_to_play got %0d exp 1", st_a); end
        pulse_tick(0);
        checks++; if (by_a !== 10'd225) begin errors++; $display("FAIL first_tick_bird_y got %0d exp 225", by_a); end
        checks++; if (px_a[10:0] !== 11'd638 || px_a[21:11] !== 11'd858) begin errors++; $display("FAIL first_tick_pipe_x got %0d,%0d exp 638,858", px_a[10:0], px_a[21:11]); end
    endtask

    task automatic test_pause();
        logic [9:0]  sy;
        logic [32:0] spx;
        pulse_tick(0);
        pulse_tick(0);
        checks++; if (by_a !== 10'd214) begin errors++; $display("FAIL pre_pause_bird_y got %0d exp 214", by_a); end
        pulse_pause(0);
        checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL pause_state got %0d exp 2", st_a); end
        sy  = by_a;
        spx = px_a;
        for (int i = 0; i < 10; i++) begin
            pulse_tick(0);
            if (i == 4) pulse_flap(0);
        end
        checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL paused_hold got %0d exp 2", st_a); end
        pulse_pause(0);
        checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL resume_state got %0d exp 1", st_a); end
        checks++; if (by_a !== sy || px_a !== spx) begin errors++; $display("FAIL paused_frozen bird_y %0d exp %0d pipe_x %h exp %h", by_a, sy, px_a, spx); end
        pulse_tick(0);
        checks++; if (by_a !== 10'd210) begin errors++; $display("FAIL paused_flap_ignored bird_y got %0d exp 210", by_a); end
        checks++; if (px_a[10:0] !== 11'd632) begin errors++; $display("FAIL resume_pipe_x got %0d exp 632", px_a[10:0]); end
    endtask

    task automatic test_pause_vs_collision();
        bit found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            tick_v[0] = 1'b1; cyc(); tick_v[0] = 1'b0;
            if (int'(by_a) + 16 >= 480) found = 1'b1;
            else cyc();
        end
        checks++; if (!found) begin errors++; $display("FAIL floor_timeout bird_y %0d exp >= 464", by_a); end
        checks++; if (by_a !== 10'd469) begin errors++; $display("FAIL floor_bird_y got %0d exp 469", by_a); end
        pulse_pause(0);
        checks++; if (st_a !== 2'd3 || hit_a !== 1'b1) begin errors++; $display("FAIL pause_vs_collision state %0d hit %0d exp 3,1", st_a, hit_a); end
        cyc();
        checks++; if (st_a !== 2'd3 || hit_a !== 1'b0) begin errors++; $display("FAIL dead_hold state %0d hit %0d exp 3,0", st_a, hit_a); end
    endtask

    task automatic test_dead_restart();
        logic [32:0] spx;
        spx = px_a;
        pulse_tick(0); pulse_tick(0); pulse_tick(0);
        pulse_pause(0);
        cyc();
        checks++; if (st_a !== 2'd3 || by_a !== 10'd469 || px_a !== spx) begin errors++; $display("FAIL dead_frozen state %0d bird_y %0d exp 3,469", st_a, by_a); end
        pulse_flap(0);
        checks++; if (st_a !== 2'd0 || by_a !== 10'd232) begin errors++; $display("FAIL restart state %0d bird_y %0d exp 0,232", st_a, by_a); end
        checks++; if (px_a !== {11'd1080, 11'd860, 11'd640} || cs_a !== 10'd0 || hs_a !== 10'd0) begin errors++; $display("FAIL restart_geom pipe_x %h cs %0d hs %0d", px_a, cs_a, hs_a); end
    endtask

    task automatic test_fall();
        int n = 0;
        logic [1:0] st_tick = 2'd0;
        pulse_flap(0);
        while (st_a !== 2'd3 && n < 100) begin
            tick_v[0] = 1'b1; cyc(); tick_v[0] = 1'b0;
            st_tick = st_a;
            cyc();
            n++;
        end
        checks++; if (n != 39) begin errors++; $display("FAIL fall_ticks got %0d exp 39", n); end
        checks++; if (by_a !== 10'd469 || st_tick !== 2'd1) begin errors++; $display("FAIL fall_bird_y %0d state_at_tick %0d exp 469,1", by_a, st_tick); end
        checks++; if (hit_a !== 1'b1) begin errors++; $display("FAIL hit_pulse got %0d exp 1", hit_a); end
        cyc();
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL hit_single got %0d exp 0", hit_a); end
        pulse_tick(0);
        checks++; if (by_a !== 10'd469) begin errors++; $display("FAIL dead_tick bird_y got %0d exp 469", by_a); end
        pulse_flap(0);
        checks++; if (st_a !== 2'd0 || by_a !== 10'd232 || hs_a !== 10'd0) begin errors++; $display("FAIL fall_restart state %0d bird_y %0d hs %0d", st_a, by_a, hs_a); end
    endtask

    task automatic test_ceiling();
        pulse_flap(0);
        pulse_tick(0);
        for (int k = 0; k < 28; k++) begin
            pulse_flap(0);
            pulse_flap(0);
            pulse_tick(0);
        end
        checks++; if (by_a !== 10'd1) begin errors++; $display("FAIL flap_collapse bird_y got %0d exp 1", by_a); end
        pulse_flap(0);
        pulse_tick(0);
        checks++; if (by_a !== 10'd0 || st_a !== 2'd1) begin errors++; $display("FAIL ceiling bird_y %0d state %0d exp 0,1", by_a, st_a); end
        pulse_tick(0);
        checks++; if (by_a !== 10'd1) begin errors++; $display("FAIL ceiling_vy bird_y got %0d exp 1", by_a); end
    endtask

    task automatic test_score();
        pulse_flap(1);
        for (int i = 0; i < 260; i++) pulse_tick(1);
        checks++; if (px_b[10:0] !== 11'd120 || cs_b !== 10'd0) begin errors++; $display("FAIL score_edge pipe_x %0d cs %0d exp 120,0", px_b[10:0], cs_b); end
        tick_v[1] = 1'b1; cyc(); tick_v[1] = 1'b0;
        checks++; if (px_b[10:0] !== 11'd118 || cs_b !== 10'd1) begin errors++; $display("FAIL score_pass pipe_x %0d cs %0d exp 118,1", px_b[10:0], cs_b); end
        checks++; if (hs_b !== 10'd0 || px_b[21:11] !== 11'd338) begin errors++; $display("FAIL score_hs_lag hs %0d pipe1 %0d exp 0,338", hs_b, px_b[21:11]); end
        cyc();
        checks++; if (hs_b !== 10'd1 || st_b !== 2'd1 || hit_b !== 1'b0) begin errors++; $display("FAIL score_hs hs %0d state %0d exp 1,1", hs_b, st_b); end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_gap;
        pulse_flap(2);
        for (int i = 0; i < 319; i++) pulse_tick(2);
        checks++; if (px_c !== 11'd2 || st_c !== 2'd1 || cs_c !== 10'd1) begin errors++; $display("FAIL wrap_pre pipe_x %0d state %0d cs %0d exp 2,1,1", px_c, st_c, cs_c); end
        tick_v[2] = 1'b1; cyc(); tick_v[2] = 1'b0;
        exp_gap = 9'd40 + {1'b0, lfsr_prev};
        checks++; if (px_c !== 11'd220) begin errors++; $display("FAIL wrap_x got %0d exp 220", px_c); end
        checks++; if (gy_c !== exp_gap) begin errors++; $display("FAIL wrap_gap got %0d exp %0d", gy_c, exp_gap); end
        cyc();
        checks++; if (cs_c !== 10'd1 || hs_c !== 10'd1 || hit_c !== 1'b0 || by_c !== 10'd292) begin errors++; $display("FAIL wrap_post cs %0d hs %0d hit %0d bird_y %0d", cs_c, hs_c, hit_c, by_c); end
    endtask

    task automatic test_midgame_reset();
        clr_n = 1'b0;
        #2;
        checks++; if (st_a !== 2'd0 || by_a !== 10'd232 || px_a !== {11'd1080, 11'd860, 11'd640}) begin errors++; $display("FAIL async_reset state %0d bird_y %0d pipe_x %h", st_a, by_a, px_a); end
        checks++; if (hs_b !== 10'd0 || cs_b !== 10'd0 || px_c !== 11'd640 || gy_c !== 9'd205) begin errors++; $display("FAIL async_reset_scores hs_b %0d cs_b %0d px_c %0d gy_c %0d", hs_b, cs_b, px_c, gy_c); end
        cyc();
        clr_n = 1'b1;
        cyc();
    endtask

    initial begin
        tick_v  = '0;
        flap_v  = '0;
        pause_v = '0;
        clr_n   = 1'b0;
        test_reset();
        test_first_tick();
        test_pause();
        test_pause_vs_collision();
        test_dead_restart();
        test_fall();
        test_ceiling();
        test_score();
        test_wrap();
        test_midgame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
